// File: rtl/multicycle_ctrl_v2_if.sv
// Control bus between the multicycle controller and the shared-memory datapath.
// master: controller side (reads opcode/mem_ready, drives strobes and selects).
// slave:  datapath side.
interface multicycle_ctrl_v2_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       i_or_d;
    logic       ce;
    logic       oce;
    logic       wre;
    logic       pc_we;
    logic       pc_we_cond;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output i_or_d, ce, oce, wre, pc_we, pc_we_cond, pc_src, mem_to_reg,
               ir_we, reg_we, alu_src_a, alu_src_b, alu_op, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  i_or_d, ce, oce, wre, pc_we, pc_we_cond, pc_src, mem_to_reg,
               ir_we, reg_we, alu_src_a, alu_src_b, alu_op, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// Main FSM of the multicycle RV32 core: memory strobes, PC/IR/regfile enables,
// ALU operand and operation selects. Memory states (FETCH, MEM_READ, MEM_WRITE)
// are held MEM_LAT cycles, or until mem_ready when MEM_HANDSHAKE_EN is defined.
// Outputs are a decode of the current state, so async rst drops them at once.
module multicycle_ctrl_v2 #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_ctrl_v2_if.master bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        WB_MEM    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        WB_ALU    = 4'd9,
        BRANCH    = 4'd10,
        JAL       = 4'd11,
        LUI       = 4'd12,
        TRAP      = 4'd13
    } state_t;

    state_t state;
    state_t nextState;
    logic   memDone;

`ifdef MEM_HANDSHAKE_EN
    assign memDone = bus.mem_ready;
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] waitCnt;
    logic             memState;

    assign memState = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign memDone  = (waitCnt == LAST_CNT);

    // Wait counter: counts held cycles of a memory state, zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            waitCnt <= '0;
        else if (memState && (nextState == state))
            waitCnt <= waitCnt + CNT_W'(1);
        else
            waitCnt <= '0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state and control decode; every output defaults to 0.
    always_comb begin
        nextState      = state;
        bus.i_or_d     = 1'b0;
        bus.ce         = 1'b0;
        bus.oce        = 1'b0;
        bus.wre        = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_we_cond = 1'b0;
        bus.pc_src     = 2'b00;
        bus.mem_to_reg = 2'b00;
        bus.ir_we      = 1'b0;
        bus.reg_we     = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.illegal    = 1'b0;
        case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                bus.ce        = 1'b1;
                bus.oce       = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_we     = memDone;
                bus.pc_we     = memDone;
                if (memDone) nextState = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'b10;
                case (bus.opcode)
                    7'h03, 7'h23: nextState = MEM_ADDR;
                    7'h33:        nextState = EXEC_R;
                    7'h13:        nextState = EXEC_I;
                    7'h63:        nextState = BRANCH;
                    7'h6F:        nextState = JAL;
                    7'h37:        nextState = LUI;
                    default:      nextState = TRAP;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                nextState     = (bus.opcode == 7'h23) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                bus.i_or_d = 1'b1;
                bus.ce     = 1'b1;
                bus.oce    = 1'b1;
                if (memDone) nextState = WB_MEM;
            end
            WB_MEM: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 2'b01;
                nextState      = FETCH;
            end
            MEM_WRITE: begin
                bus.i_or_d = 1'b1;
                bus.ce     = 1'b1;
                bus.oce    = 1'b1;
                bus.wre    = 1'b1;
                if (memDone) nextState = FETCH;
            end
            EXEC_R: begin
                bus.alu_src_a = 2'b01;
                bus.alu_op    = 2'b10;
                nextState     = WB_ALU;
            end
            EXEC_I: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 2'b11;
                nextState     = WB_ALU;
            end
            WB_ALU: begin
                bus.reg_we = 1'b1;
                nextState  = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a  = 2'b01;
                bus.alu_op     = 2'b01;
                bus.pc_we_cond = 1'b1;
                bus.pc_src     = 2'b01;
                nextState      = FETCH;
            end
            JAL: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 2'b10;
                bus.pc_we      = 1'b1;
                bus.pc_src     = 2'b01;
                nextState      = FETCH;
            end
            LUI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b10;
                nextState     = WB_ALU;
            end
            TRAP: begin
                bus.illegal = 1'b1;
                nextState   = TRAP;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule
